muldiv_seq: RTL and testbench

- Sequencer for the EX-stage multi-cycle multiply and divide units.
- Accepts one MULT/MULTU/DIV/DIVU operation from EX and holds the pipeline stalled while the operation runs.
- Drives the pipelined multiplier (fixed latency) and the handshaked divider.
- Returns one registered HI/LO write per operation for the EX-to-MEM and EX-to-ID buses.

---
 rtl/muldiv_seq.sv | 146 ++++++++++++++
 tb/tb_muldiv_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// EX-stage sequencer for the multi-cycle multiply and divide units.
// Stalls the pipeline while an operation runs and returns one registered HI/LO write.
module muldiv_seq #(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [1:0]  op_sel,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        stallreq_for_ex,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [1:0]       sel_q, sel_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (op_valid && !flush) begin
                    a_d   = op_a;
                    b_d   = op_b;
                    sel_d = op_sel;
                    if (!op_sel[1]) begin
                        state_d = MUL_WAIT;
                        cnt_d   = CNT_INIT;
                    end else if (op_b != 32'd0) begin
                        state_d = DIV_WAIT;
                    end else begin
                        // Divide by zero resolves without the divider: HI=dividend, LO=all ones.
                        state_d = DONE;
                        hi_d    = op_a;
                        lo_d    = 32'hFFFF_FFFF;
                    end
                end
            end
            MUL_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    hi_d    = mul_result[63:32];
                    lo_d    = mul_result[31:0];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DIV_WAIT: begin
                if (div_ready) begin
                    state_d = DONE;
                    hi_d    = div_result[63:32];
                    lo_d    = div_result[31:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A cancelled operation must leave HI/LO untouched.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    assign busy            = (state_q != IDLE);
    assign stallreq_for_ex = ((state_q == IDLE) && op_valid && !flush)
                           || (state_q == MUL_WAIT) || (state_q == DIV_WAIT);
    assign hilo_we         = (state_q == DONE) && !flush && !rst;

    assign mul_signed  = (state_q == MUL_WAIT) && (sel_q == 2'b00);
    assign mul_ina     = (state_q == MUL_WAIT) ? a_q : 32'd0;
    assign mul_inb     = (state_q == MUL_WAIT) ? b_q : 32'd0;

    assign div_start   = (state_q == DIV_WAIT) && !flush;
    assign div_signed  = (state_q == DIV_WAIT) && (sel_q == 2'b10);
    assign div_opdata1 = (state_q == DIV_WAIT) ? a_q : 32'd0;
    assign div_opdata2 = (state_q == DIV_WAIT) ? b_q : 32'd0;
    assign div_annul   = (state_q == DIV_WAIT) && flush && !rst;

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a one-stage multiplier model and a fixed-latency divider model.
module tb_muldiv_seq;

    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        mul_signed;
    logic [31:0] mul_ina;
    logic [31:0] mul_inb;
    logic [63:0] mul_result = 64'd0;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_opdata1;
    logic [31:0] div_opdata2;
    logic        div_annul;
    logic [63:0] div_result;
    logic        div_ready;
    logic        stallreq_for_ex;
    logic        hilo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy;

    logic        stray_ready;
    int          dcnt = 0;
    int          we_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    muldiv_seq #(.MUL_LAT(MUL_LAT), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_sel(op_sel),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
        .mul_result(mul_result),
        .div_start(div_start), .div_signed(div_signed),
        .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
        .div_annul(div_annul), .div_result(div_result), .div_ready(div_ready),
        .stallreq_for_ex(stallreq_for_ex), .hilo_we(hilo_we),
        .hi_o(hi_o), .lo_o(lo_o), .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier: operands presented in one cycle give a product in the next.
    always @(posedge clk) begin
        if (mul_signed)
            mul_result <= {{32{mul_ina[31]}}, mul_ina} * {{32{mul_inb[31]}}, mul_inb};
        else
            mul_result <= {32'd0, mul_ina} * {32'd0, mul_inb};
    end

    // Divider: ready in the 33rd consecutive cycle of div_start.
    always @(posedge clk) begin
        if (rst || !div_start) dcnt <= 0;
        else                   dcnt <= dcnt + 1;
        if (hilo_we) we_cnt <= we_cnt + 1;
    end
    assign div_ready = (div_start && dcnt == 32) || stray_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in the accept cycle; returns in the DONE cycle.
    task automatic mul_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        op_valid = 1'b1;
        op_sel   = sel;
        op_a     = a;
        op_b     = b;
        #1;
        check("mul_c0_stall", 64'(stallreq_for_ex), 64'd1);
        for (int c = 1; c <= MUL_LAT; c++) begin
            tick();
            check("mul_wait_stall", 64'(stallreq_for_ex), 64'd1);
            check("mul_wait_busy", 64'(busy), 64'd1);
            check("mul_ina", 64'(mul_ina), 64'(a));
            check("mul_inb", 64'(mul_inb), 64'(b));
            check("mul_signed", 64'(mul_signed), 64'(sel == 2'b00));
            check("mul_wait_we", 64'(hilo_we), 64'd0);
        end
        tick();
        check("mul_done_we", 64'(hilo_we), 64'd1);
        check("mul_done_stall", 64'(stallreq_for_ex), 64'd0);
        check("mul_hi", 64'(hi_o), 64'(eh));
        check("mul_lo", 64'(lo_o), 64'(el));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts;
        int guard;
        int we_before;
        logic rdy;

        rst = 1'b1; op_valid = 1'b0; op_sel = 2'b00; op_a = 32'd0; op_b = 32'd0;
        flush = 1'b0; div_result = 64'd0; stray_ready = 1'b0;
        tick(); tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stallreq_for_ex), 64'd0);
        check("rst_we", 64'(hilo_we), 64'd0);
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        check("rst_div_start", 64'(div_start), 64'd0);
        rst = 1'b0;

        // MULT -3 * 5
        tick();
        mul_op(2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        tick();
        op_valid = 1'b0;
        #1;
        check("mult_after_we", 64'(hilo_we), 64'd0);
        check("mult_after_busy", 64'(busy), 64'd0);

        // MULTU back-to-back
        tick();
        mul_op(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        tick();
        mul_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12);
        tick();
        op_valid = 1'b0;

        // DIV -7 / 2
        tick();
        op_valid = 1'b1; op_sel = 2'b10; op_a = 32'hFFFF_FFF9; op_b = 32'd2;
        div_result = 64'hFFFF_FFFF_FFFF_FFFD;
        #1;
        check("div_c0_stall", 64'(stallreq_for_ex), 64'd1);
        check("div_c0_start", 64'(div_start), 64'd0);
        starts = 0; guard = 0; rdy = 1'b0;
        while (!rdy && guard < 100) begin
            tick();
            guard++;
            if (div_start) starts++;
            rdy = div_ready;
        end
        check("div_start_cycles", 64'(starts), 64'd33);
        check("div_signed", 64'(div_signed), 64'd1);
        check("div_opdata1", 64'(div_opdata1), 64'h0000_0000_FFFF_FFF9);
        check("div_opdata2", 64'(div_opdata2), 64'd2);
        check("div_wait_stall", 64'(stallreq_for_ex), 64'd1);
        tick();
        check("div_done_we", 64'(hilo_we), 64'd1);
        check("div_done_stall", 64'(stallreq_for_ex), 64'd0);
        check("div_done_start", 64'(div_start), 64'd0);
        check("div_hi", 64'(hi_o), 64'h0000_0000_FFFF_FFFF);
        check("div_lo", 64'(lo_o), 64'h0000_0000_FFFF_FFFD);
        tick();
        op_valid = 1'b0;

        // DIVU 9 / 0
        tick();
        op_valid = 1'b1; op_sel = 2'b11; op_a = 32'd9; op_b = 32'd0;
        #1;
        check("dz_c0_stall", 64'(stallreq_for_ex), 64'd1);
        tick();
        check("dz_we", 64'(hilo_we), 64'd1);
        check("dz_start", 64'(div_start), 64'd0);
        check("dz_hi", 64'(hi_o), 64'd9);
        check("dz_lo", 64'(lo_o), 64'h0000_0000_FFFF_FFFF);
        tick();
        op_valid = 1'b0;
        #1;
        check("dz_after_busy", 64'(busy), 64'd0);

        // flush in DIV_WAIT cycle 10, then a stray div_ready
        tick();
        we_before = we_cnt;
        op_valid = 1'b1; op_sel = 2'b10; op_a = 32'd100; op_b = 32'd7;
        div_result = 64'h0000_0002_0000_000E;
        for (int c = 1; c <= 9; c++) tick();
        tick();
        flush = 1'b1; op_valid = 1'b0;
        #1;
        check("fl_annul", 64'(div_annul), 64'd1);
        check("fl_start", 64'(div_start), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check("fl_busy", 64'(busy), 64'd0);
        check("fl_annul_end", 64'(div_annul), 64'd0);
        check("fl_stall", 64'(stallreq_for_ex), 64'd0);
        for (int c = 0; c < 4; c++) tick();
        stray_ready = 1'b1;
        tick();
        stray_ready = 1'b0;
        tick(); tick();
        check("fl_stray_busy", 64'(busy), 64'd0);
        check("fl_no_we", 64'(we_cnt), 64'(we_before));
        check("fl_hi_hold", 64'(hi_o), 64'd9);

        // op_valid with flush in IDLE is not accepted
        tick();
        op_valid = 1'b1; op_sel = 2'b00; flush = 1'b1;
        #1;
        check("idle_fl_stall", 64'(stallreq_for_ex), 64'd0);
        tick();
        op_valid = 1'b0; flush = 1'b0;
        #1;
        check("idle_fl_busy", 64'(busy), 64'd0);

        // rst during MUL_WAIT, then a normal MULT
        tick();
        mul_op(2'b00, 32'd7, 32'd6, 32'd0, 32'd42);
        tick();
        op_valid = 1'b0;
        tick();
        op_valid = 1'b1; op_sel = 2'b00; op_a = 32'd7; op_b = 32'd5;
        tick();
        rst = 1'b1; op_valid = 1'b0;
        #1;
        check("rst_mid_we", 64'(hilo_we), 64'd0);
        check("rst_mid_annul", 64'(div_annul), 64'd0);
        tick();
        check("rst2_busy", 64'(busy), 64'd0);
        check("rst2_stall", 64'(stallreq_for_ex), 64'd0);
        check("rst2_hi", 64'(hi_o), 64'd0);
        check("rst2_lo", 64'(lo_o), 64'd0);
        check("rst2_ina", 64'(mul_ina), 64'd0);
        rst = 1'b0;
        tick();
        mul_op(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6);
        tick();
        op_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
